// File: rtl/magic_lock_if.sv
// Key-entry bus for magic_lock: byte stream and control in, lock status out.
interface magic_lock_if;
  logic       ena;
  logic [7:0] din;
  logic       din_valid;
  logic       clear;
  logic       unlocked;
  logic       fail;
  logic       locked_out;
  logic [3:0] tries_left;
  logic [3:0] byte_cnt;

  modport master (
    output ena, din, din_valid, clear,
    input  unlocked, fail, locked_out, tries_left, byte_cnt
  );

  modport slave (
    input  ena, din, din_valid, clear,
    output unlocked, fail, locked_out, tries_left, byte_cnt
  );
endinterface

// File: rtl/magic_lock.sv
// Byte-serial combination lock with retry limit; define MAGIC_LOCK_LOCKOUT_EN
// to enable the tries_left countdown and the timed LOCKOUT state.
module magic_lock #(
  parameter int                    KEY_LEN        = 4,
  parameter logic [KEY_LEN*8-1:0]  KEY            = 32'hCAFEF00D,
  parameter int                    MAX_TRIES      = 3,
  parameter int                    LOCKOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  magic_lock_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, UNLOCKED, LOCKOUT} state_t;

  state_t     state_q,    state_d;
  logic [3:0] byte_cnt_q, byte_cnt_d;
  logic       mismatch_q, mismatch_d;
  logic       unlocked_q, unlocked_d;
  logic       fail_q,     fail_d;
  logic [7:0] key_byte;
`ifdef MAGIC_LOCK_LOCKOUT_EN
  logic [3:0]  tries_q,      tries_d;
  logic        locked_out_q, locked_out_d;
  logic [15:0] lock_cnt_q,   lock_cnt_d;
`endif

  // Key is compared most-significant byte first.
  always_comb begin
    key_byte = '0;
    for (int i = 0; i < KEY_LEN; i++) begin
      if (byte_cnt_q == 4'(i)) key_byte = KEY[(KEY_LEN-1-i)*8 +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    mismatch_d = mismatch_q;
    unlocked_d = unlocked_q;
    fail_d     = 1'b0;
`ifdef MAGIC_LOCK_LOCKOUT_EN
    tries_d      = tries_q;
    locked_out_d = locked_out_q;
    lock_cnt_d   = lock_cnt_q;
`endif
    if (bus.ena) begin
      case (state_q)
        IDLE, ENTRY: begin
          if (state_q == ENTRY && bus.clear) begin
            state_d    = IDLE;
            byte_cnt_d = '0;
            mismatch_d = 1'b0;
          end else if (bus.din_valid) begin
            byte_cnt_d = byte_cnt_q + 4'd1;
            mismatch_d = mismatch_q | (bus.din != key_byte);
            state_d    = (byte_cnt_q == 4'(KEY_LEN-1)) ? CHECK : ENTRY;
          end
        end
        CHECK: begin
          byte_cnt_d = '0;
          mismatch_d = 1'b0;
          if (!mismatch_q) begin
            state_d    = UNLOCKED;
            unlocked_d = 1'b1;
`ifdef MAGIC_LOCK_LOCKOUT_EN
            tries_d    = 4'(MAX_TRIES);
`endif
          end else begin
            fail_d  = 1'b1;
            state_d = IDLE;
`ifdef MAGIC_LOCK_LOCKOUT_EN
            tries_d = tries_q - 4'd1;
            if (tries_q == 4'd1) begin
              state_d      = LOCKOUT;
              locked_out_d = 1'b1;
              lock_cnt_d   = '0;
            end
`endif
          end
        end
        UNLOCKED: begin
          if (bus.clear) begin
            state_d    = IDLE;
            unlocked_d = 1'b0;
          end
        end
`ifdef MAGIC_LOCK_LOCKOUT_EN
        LOCKOUT: begin
          // Exits on the LOCKOUT_CYCLES-th enabled edge after entry.
          if (lock_cnt_q == 16'(LOCKOUT_CYCLES-1)) begin
            state_d      = IDLE;
            locked_out_d = 1'b0;
            tries_d      = 4'(MAX_TRIES);
            lock_cnt_d   = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 16'd1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      mismatch_q   <= 1'b0;
      unlocked_q   <= 1'b0;
      fail_q       <= 1'b0;
`ifdef MAGIC_LOCK_LOCKOUT_EN
      tries_q      <= 4'(MAX_TRIES);
      locked_out_q <= 1'b0;
      lock_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      mismatch_q   <= mismatch_d;
      unlocked_q   <= unlocked_d;
      fail_q       <= fail_d;
`ifdef MAGIC_LOCK_LOCKOUT_EN
      tries_q      <= tries_d;
      locked_out_q <= locked_out_d;
      lock_cnt_q   <= lock_cnt_d;
`endif
    end
  end

  assign bus.unlocked = unlocked_q;
  assign bus.fail     = fail_q;
  assign bus.byte_cnt = byte_cnt_q;
`ifdef MAGIC_LOCK_LOCKOUT_EN
  assign bus.tries_left = tries_q;
  assign bus.locked_out = locked_out_q;
`else
  assign bus.tries_left = 4'(MAX_TRIES);
  assign bus.locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_magic_lock.sv
// Scoreboard bench for magic_lock: a queue-based reference model predicts the
// outputs after every clock edge; a monitor compares them one cycle at a time.
module tb_magic_lock;
  localparam int          KEY_LEN = 4;
  localparam logic [31:0] KEY     = 32'hCAFEF00D;
  localparam int          MAXT    = 3;
  localparam int          LCYC    = 16;

  typedef struct packed {
    logic       unl;
    logic       fl;
    logic       lo;
    logic [3:0] tries;
    logic [3:0] bc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  magic_lock_if bus();

  magic_lock #(.KEY_LEN(KEY_LEN), .KEY(KEY), .MAX_TRIES(MAXT), .LOCKOUT_CYCLES(LCYC))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   shown  = 0;
  exp_t exp_q[$];

  // Reference model state: bytes typed so far, and plain counters.
  logic [7:0] key_bytes[KEY_LEN];
  logic [7:0] entered[$];
  bit pending, m_unl, m_fail;
  int lock_rem, m_tries;

  function automatic void model_reset();
    entered.delete();
    pending = 0; m_unl = 0; m_fail = 0; lock_rem = 0; m_tries = MAXT;
  endfunction

  function automatic bit key_ok();
    if (entered.size() != KEY_LEN) return 0;
    for (int i = 0; i < KEY_LEN; i++) if (entered[i] != key_bytes[i]) return 0;
    return 1;
  endfunction

  function automatic void model_step(bit r, bit e, bit v, logic [7:0] d, bit c);
    m_fail = 0;
    if (r) begin
      model_reset();
    end else if (!e) begin
      // frozen
    end else if (pending) begin
      pending = 0;
      if (key_ok()) begin
        m_unl = 1; m_tries = MAXT;
      end else begin
        m_fail = 1;
`ifdef MAGIC_LOCK_LOCKOUT_EN
        m_tries--;
        if (m_tries == 0) lock_rem = LCYC;
`endif
      end
      entered.delete();
    end else if (lock_rem > 0) begin
      lock_rem--;
      if (lock_rem == 0) m_tries = MAXT;
    end else if (m_unl) begin
      if (c) m_unl = 0;
    end else if (c && entered.size() > 0) begin
      entered.delete();
    end else if (v) begin
      entered.push_back(d);
      if (entered.size() == KEY_LEN) pending = 1;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t x;
    x.unl = m_unl; x.fl = m_fail; x.lo = (lock_rem > 0);
    x.tries = 4'(m_tries); x.bc = 4'(entered.size());
    return x;
  endfunction

  task automatic drive(input bit r, input bit e, input bit v, input logic [7:0] d, input bit c);
    bit was_rst;
    @(negedge clk);
    was_rst = rst;
    rst = r; bus.ena = e; bus.din_valid = v; bus.din = d; bus.clear = c;
    model_step(r, e, v, d, c);
    exp_q.push_back(model_out());
    if (r && !was_rst) begin
      // Reset is asynchronous: outputs must clear before any edge.
      #1;
      checks++;
      if (bus.tries_left !== 4'(MAXT) || bus.locked_out !== 1'b0 || bus.unlocked !== 1'b0 || bus.byte_cnt !== 4'd0) begin
        errors++;
        $display("FAIL async_reset: tries=%0d lo=%0b unl=%0b cnt=%0d required tries=%0d lo=0 unl=0 cnt=0",
                 bus.tries_left, bus.locked_out, bus.unlocked, bus.byte_cnt, MAXT);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 8'h00, 0);
  endtask

  task automatic send_key(input logic [31:0] k);
    for (int i = 0; i < 4; i++) drive(0, 1, 1, k[31-8*i -: 8], 0);
    idle(2);
  endtask

  // Monitor: compare every registered output one step after each edge.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.unlocked, bus.fail, bus.locked_out, bus.tries_left, bus.byte_cnt};
        checks++;
        if (a !== e) begin
          errors++;
          if (shown < 40) begin
            shown++;
            $display("FAIL outputs t=%0t: unl=%0b fail=%0b lo=%0b tries=%0d cnt=%0d required unl=%0b fail=%0b lo=%0b tries=%0d cnt=%0d",
                     $time, a.unl, a.fl, a.lo, a.tries, a.bc, e.unl, e.fl, e.lo, e.tries, e.bc);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    int n;
    for (int i = 0; i < KEY_LEN; i++) key_bytes[i] = KEY[31-8*i -: 8];
    model_reset();
    bus.ena = 1'b0; bus.din = '0; bus.din_valid = 1'b0; bus.clear = 1'b0;

    drive(1, 1, 1, 8'hCA, 0);
    drive(1, 1, 0, 8'h00, 0);
    idle(2);

    // Correct key, dwell unlocked, then relock with clear.
    send_key(32'hCAFEF00D);
    drive(0, 1, 1, 8'hCA, 0);
    drive(0, 1, 0, 8'h00, 1);
    idle(2);

    // Last byte wrong.
    send_key(32'hCAFEF00E);

    // Abort mid-entry: clear beats simultaneous din_valid.
    drive(0, 1, 1, 8'hCA, 0);
    drive(0, 1, 1, 8'hFE, 0);
    drive(0, 1, 1, 8'hF0, 1);
    idle(1);
    send_key(32'hCAFEF00D);
    drive(0, 1, 0, 8'h00, 1);

    // ena low mid-entry.
    drive(0, 1, 1, 8'hCA, 0);
    drive(0, 1, 1, 8'hFE, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 8'($urandom), 1);
    drive(0, 1, 1, 8'hF0, 0);
    drive(0, 1, 1, 8'h0D, 0);
    idle(2);
    drive(0, 1, 0, 8'h00, 1);

    // Four wrong keys, correct key during any lockout, wait it out.
    for (int i = 0; i < 4; i++) send_key(32'h12345678);
    send_key(32'hCAFEF00D);
    idle(LCYC + 2);
    send_key(32'hCAFEF00D);
    drive(0, 1, 0, 8'h00, 1);

    // ena low mid-lockout.
    for (int i = 0; i < 3; i++) send_key(32'hCAFEF000);
    idle(3);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 8'h00, 0);
    idle(LCYC);

    // Reset pulse mid-lockout.
    for (int i = 0; i < 3; i++) send_key(32'h00FEF00D);
    idle(4);
    drive(1, 1, 0, 8'h00, 0);
    send_key(32'hCAFEF00D);
    drive(0, 1, 0, 8'h00, 1);

    // Random traffic, biased toward correct bytes so unlocks happen.
    for (int i = 0; i < 3000; i++) begin
      n = entered.size();
      if (n < KEY_LEN && $urandom_range(0, 9) < 8) d = key_bytes[n];
      else d = 8'($urandom);
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) < 6, d, $urandom_range(0, 19) == 0);
    end
    idle(2);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/magic_lock.md
MAGIC_LOCK -- requirements
Module: magic_lock

Interface
REQ-001 SHALL have parameter KEY_LEN, default 4, key length in bytes (legal 1..8).
REQ-002 SHALL have parameter KEY, default 32'hCAFEF00D, KEY_LEN*8-bit secret, compared MSB byte first.
REQ-003 SHALL have parameter MAX_TRIES, default 3, failed attempts before lockout (legal 1..15).
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 1024, lockout duration in clk cycles (legal 1..65535).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port ena  input  1  when low, all state is frozen and inputs are ignored.
REQ-008 SHALL have port din  input  8  key byte.
REQ-009 SHALL have port din_valid  input  1  din is accepted on the edge where this is high.
REQ-010 SHALL have port clear  input  1  aborts entry or relocks.
REQ-011 SHALL have port unlocked  output  1  registered, high while in UNLOCKED.
REQ-012 SHALL have port fail  output  1  registered one-cycle pulse per wrong key.
REQ-013 SHALL have port locked_out  output  1  registered, high while in LOCKOUT.
REQ-014 SHALL have port tries_left  output  4  remaining attempts.
REQ-015 SHALL have port byte_cnt  output  4  bytes accepted in the current attempt.

Function
REQ-016 SHALL implement states IDLE, ENTRY, CHECK, UNLOCKED and LOCKOUT.
REQ-017 SHALL, in IDLE or ENTRY with din_valid=1, accept din, increment byte_cnt, and OR (din != KEY byte[byte_cnt]) into a sticky mismatch flag.
REQ-018 SHALL move from IDLE to ENTRY on the first accepted byte, and to CHECK on the edge that accepts byte KEY_LEN.
REQ-019 SHALL spend exactly one cycle in CHECK, during which din_valid and clear are ignored.
REQ-020 SHALL, on leaving CHECK with mismatch=0, enter UNLOCKED: unlocked=1, tries_left=MAX_TRIES, byte_cnt=0, mismatch cleared.
REQ-021 SHALL, on leaving CHECK with mismatch=1, assert fail for exactly one cycle, decrement tries_left, clear byte_cnt and mismatch, and go to IDLE, or to LOCKOUT if tries_left reaches 0.
REQ-022 SHALL give latency: last byte at edge N, so unlocked or fail is high after edge N+1.
REQ-023 SHALL, on clear in ENTRY, go to IDLE with byte_cnt=0, mismatch cleared and tries_left unchanged; clear wins over a simultaneous din_valid.
REQ-024 SHALL, on clear in UNLOCKED, go to IDLE with unlocked=0 after that edge; din_valid is ignored in UNLOCKED.
REQ-025 SHALL, in LOCKOUT, ignore din_valid and clear, count LOCKOUT_CYCLES cycles, then go to IDLE with tries_left=MAX_TRIES and locked_out=0.
REQ-026 SHALL, with ena=0, hold every register including the lockout counter, and SHALL NOT extend fail beyond one enabled cycle.
REQ-027 SHALL NOT let byte_cnt exceed KEY_LEN; wrap-around is not possible.

Reset
REQ-028 SHALL, on rst=1, asynchronously force IDLE, byte_cnt=0, mismatch=0, tries_left=MAX_TRIES, unlocked=0, fail=0, locked_out=0, and clear the lockout counter.
REQ-029 SHALL, on reset mid-entry, mid-lockout or while UNLOCKED, discard all progress; the first edge after deassertion behaves as IDLE.

Configuration
REQ-030 SHALL treat macro MAGIC_LOCK_LOCKOUT_EN as enabling REQ-025 and the tries_left decrement of REQ-021.
REQ-031 SHALL, without MAGIC_LOCK_LOCKOUT_EN, make a wrong key pulse fail and return to IDLE, hold tries_left constant at MAX_TRIES, tie locked_out to 0 and synthesise no lockout counter.

Verification (KEY=CAFEF00D, KEY_LEN=4, MAX_TRIES=3, LOCKOUT_CYCLES=16, macro defined unless noted)
REQ-032 SHALL cover: bytes CA,FE,F0,0D on consecutive cycles -> unlocked=1 two edges after 0D, tries_left=3; then clear -> unlocked=0 on next edge.
REQ-033 SHALL cover: CA,FE,F0,0E -> one-cycle fail, tries_left=2, byte_cnt=0, unlocked stays 0.
REQ-034 SHALL cover: three wrong keys -> locked_out=1 after 3rd CHECK; correct key during lockout ignored; locked_out=0 and tries_left=3 after exactly 16 cycles.
REQ-035 SHALL cover: CA,FE then clear together with din_valid=F0 -> byte_cnt=0, tries_left=3, no fail; full correct key afterwards unlocks.
REQ-036 SHALL cover: ena=0 for 5 cycles mid-entry and mid-lockout -> byte_cnt and remaining lockout count unchanged; rst pulse mid-lockout -> IDLE, tries_left=3 immediately.
REQ-037 SHALL cover: with the macro undefined, four wrong keys -> four fail pulses, tries_left=3, locked_out=0, then correct key unlocks.
